// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word-addressed memory behind a req/ack handshake with fixed latency.
// Define MEM_RESP_ERR_EN to flag misaligned/out-of-range accesses instead of wrapping them.
module mc_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} stateT;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic          bad;
    } reqT;

    stateT       state, nextState;
    logic [3:0]  waitCnt;
    reqT         capReq;
    logic [31:0] respData;
    logic        badAddr;
    logic [31:0] mem [DEPTH];

`ifdef MEM_RESP_ERR_EN
    assign badAddr = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:AW+2], addr[1:0]};
    assign badAddr = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req) nextState = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (waitCnt == 4'd1) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            capReq   <= '0;
            respData <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (req) begin
                        capReq  <= '{we: we, idx: addr[AW+1:2], wdata: wdata, bad: badAddr};
                        waitCnt <= 4'(WAIT_CYCLES);
                    end
                end
                WAIT:    waitCnt <= waitCnt - 4'd1;
                // Writes and rejected accesses both answer with zero data.
                ACCESS:  respData <= (capReq.we || capReq.bad) ? '0 : mem[capReq.idx];
                default: ;
            endcase
        end
    end

    // Contents survive reset; only the ACCESS state touches the array.
    always_ff @(posedge clk) begin
        if (state == ACCESS && capReq.we && !capReq.bad)
            mem[capReq.idx] <= capReq.wdata;
    end

    always_comb begin
        ack   = (state == RESP);
        busy  = (state != IDLE);
        rdata = ack ? respData : '0;
`ifdef MEM_RESP_ERR_EN
        err   = ack & capReq.bad;
`else
        err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder: default instance (WAIT_CYCLES=2) plus a DEPTH=4/WAIT_CYCLES=0 instance.
module tb_mc_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqA = 1'b0, reqB = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ackA, errA, busyA, ackB, errB, busyB;
    logic [31:0] rdataA, rdataB;

    int nChk = 0;
    int nErr = 0;

    logic [31:0] rd;
    logic        e, lk;
    int          lat, cyc, nAck;
    int          ackCyc [3];
    logic [31:0] ackDat [3];
    logic        sawAck, busyLow;

    always #5 clk = ~clk;

    mc_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .reset(reset), .req(reqA), .we(we), .addr(addr), .wdata(wdata),
        .ack(ackA), .rdata(rdataA), .err(errA), .busy(busyA)
    );

    mc_mem_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .reset(reset), .req(reqB), .we(we), .addr(addr), .wdata(wdata),
        .ack(ackB), .rdata(rdataB), .err(errB), .busy(busyB)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns data/err of the ack cycle, cycles from req to ack, and
    // whether rdata was nonzero outside the ack cycle. Also checks ack is a single pulse.
    task automatic txn(input bit useB, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdOut, output logic eOut, output int latOut,
                       output logic leak);
        logic got;
        we = w; addr = a; wdata = d;
        if (useB) reqB = 1'b1; else reqA = 1'b1;
        latOut = 0; got = 1'b0; leak = 1'b0; rdOut = 'x; eOut = 'x;
        while (!got && latOut < 40) begin
            @(posedge clk); latOut++;
            @(negedge clk);
            reqA = 1'b0; reqB = 1'b0;
            if (useB ? ackB : ackA) begin
                got = 1'b1;
                rdOut = useB ? rdataB : rdataA;
                eOut  = useB ? errB : errA;
            end else if ((useB ? rdataB : rdataA) != '0) begin
                leak = 1'b1;
            end
        end
        if (!got) latOut = -1;
        @(posedge clk); @(negedge clk);
        chk("ackSinglePulse", {31'b0, useB ? ackB : ackA}, 32'd0);
        chk("idleAfterAck", {31'b0, useB ? busyB : busyA}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rstAck", {31'b0, ackA}, 32'd0);
        chk("rstBusy", {31'b0, busyA}, 32'd0);
        chk("rstRdata", rdataA, 32'd0);
        chk("rstErr", {31'b0, errA}, 32'd0);
        chk("rstBusyB", {31'b0, busyB}, 32'd0);
        reset = 1'b1;

        // Basic write then read-back, WAIT_CYCLES=2 -> ack 4 cycles after req
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, lk);
        chk("wrLat", 32'(lat), 32'd4);
        chk("wrErr", {31'b0, e}, 32'd0);
        chk("wrRdataZero", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, rd, e, lat, lk);
        chk("rdLat", 32'(lat), 32'd4);
        chk("rdData", rd, 32'hDEADBEEF);
        chk("rdErr", {31'b0, e}, 32'd0);
        chk("rdNoLeak", {31'b0, lk}, 32'd0);

        // Back-to-back reads with req held high
        txn(0, 1'b1, 32'h0, 32'd1, rd, e, lat, lk);
        txn(0, 1'b1, 32'h4, 32'd2, rd, e, lat, lk);
        txn(0, 1'b1, 32'h8, 32'd3, rd, e, lat, lk);
        we = 1'b0; addr = 32'h0; reqA = 1'b1; cyc = 0; nAck = 0;
        while (nAck < 3 && cyc < 60) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (ackA) begin
                ackCyc[nAck] = cyc;
                ackDat[nAck] = rdataA;
                nAck++;
                addr = 32'(nAck * 4);
                if (nAck == 3) reqA = 1'b0;
            end
        end
        reqA = 1'b0;
        chk("b2bCount", 32'(nAck), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("b2bCycle", 32'(ackCyc[i]), 32'(4 + 5 * i));
            chk("b2bData", ackDat[i], 32'(i + 1));
        end
        @(posedge clk); @(negedge clk);
        chk("b2bIdle", {31'b0, busyA}, 32'd0);

        // Reset during WAIT aborts the write
        txn(0, 1'b1, 32'h20, 32'h11111111, rd, e, lat, lk);
        we = 1'b1; addr = 32'h20; wdata = 32'h22222222; reqA = 1'b1;
        @(posedge clk); @(negedge clk);
        reqA = 1'b0;
        chk("abortBusy", {31'b0, busyA}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abortRstBusy", {31'b0, busyA}, 32'd0);
        chk("abortRstAck", {31'b0, ackA}, 32'd0);
        chk("abortRstRdata", rdataA, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nAck = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (ackA) nAck++;
        end
        chk("abortNoAck", 32'(nAck), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, rd, e, lat, lk);
        chk("abortOldData", rd, 32'h11111111);
        chk("postRstLat", 32'(lat), 32'd4);

        // Misaligned write to 0x22
        txn(0, 1'b1, 32'h22, 32'h33333333, rd, e, lat, lk);
        chk("misLat", 32'(lat), 32'd4);
        chk("misWrRdata", rd, 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, rd, e, lat, lk);
`ifdef MEM_RESP_ERR_EN
        chk("misErr", {31'b0, errA}, 32'd0);
        chk("misRead", rd, 32'h11111111);
`else
        chk("misRead", rd, 32'h33333333);
        chk("misRdErr", {31'b0, e}, 32'd0);
`endif

        // Inputs toggling while busy are ignored
        txn(0, 1'b1, 32'h44, 32'h0, rd, e, lat, lk);
        we = 1'b1; addr = 32'h40; wdata = 32'hA5A5A5A5; reqA = 1'b1;
        cyc = 0; sawAck = 1'b0; busyLow = 1'b0;
        while (!sawAck && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            reqA = 1'b0;
            if (ackA) begin
                sawAck = 1'b1;
            end else begin
                if (!busyA) busyLow = 1'b1;
                addr = addr ^ 32'h4; wdata = ~wdata; we = ~we;
            end
        end
        chk("tglLat", 32'(cyc), 32'd4);
        chk("tglBusyHeld", {31'b0, busyLow}, 32'd0);
        chk("tglBusyAck", {31'b0, busyA}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("tglBusyAfter", {31'b0, busyA}, 32'd0);
        txn(0, 1'b0, 32'h40, 32'h0, rd, e, lat, lk);
        chk("tglData", rd, 32'hA5A5A5A5);
        txn(0, 1'b0, 32'h44, 32'h0, rd, e, lat, lk);
        chk("tglNeighbour", rd, 32'h0);

        // DEPTH=4, WAIT_CYCLES=0: 0x10 wraps to index 0
        txn(1, 1'b1, 32'h10, 32'hCAFEF00D, rd, e, lat, lk);
        chk("wrapWrLat", 32'(lat), 32'd2);
`ifdef MEM_RESP_ERR_EN
        chk("wrapWrErr", {31'b0, e}, 32'd1);
`else
        chk("wrapWrErr", {31'b0, e}, 32'd0);
        txn(1, 1'b0, 32'h0, 32'h0, rd, e, lat, lk);
        chk("wrapRdLat", 32'(lat), 32'd2);
        chk("wrapRdData", rd, 32'hCAFEF00D);
`endif

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
